// File: rtl/intlv_pkg.sv
// rtl/intlv_pkg.sv - shared bank-state encoding, bank ids and counter width helper
package intlv_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // A one-beat block still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intlv_bank_fsm.sv
// rtl/intlv_bank_fsm.sv - per-bank EMPTY/FILLING/FULL/DRAINING occupancy state machine
module intlv_bank_fsm
    import intlv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_hit,
    input  logic        wr_done,
    input  logic        rd_hit,
    input  logic        rd_done,
    output bank_state_e state
);

    bank_state_e state_q;

    // done strobes take priority so one-beat blocks skip the middle state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (wr_done)     state_q <= FULL;
                    else if (wr_hit) state_q <= FILLING;
                end
                FILLING: begin
                    if (wr_done) state_q <= FULL;
                end
                FULL: begin
                    if (rd_done)     state_q <= EMPTY;
                    else if (rd_hit) state_q <= DRAINING;
                end
                DRAINING: begin
                    if (rd_done) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/interleave_bank_sched.sv
// rtl/interleave_bank_sched.sv - ping-pong bank scheduler; INTLV_SCHED_STATS_EN adds blk/stall/err counters
module interleave_bank_sched
    import intlv_pkg::*;
#(
    parameter int row = 512,
    parameter int col = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_beat,
    input  logic        out_beat,
    input  logic        out_last,
    output logic        in_sel,
    output logic        out_sel,
    output logic        in_en,
    output logic        out_en,
    output logic [1:0]  bank_full,
`ifdef INTLV_SCHED_STATS_EN
    output logic [15:0] blk_cnt,
    output logic [15:0] stall_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        err
);

    localparam int blk   = row * col;
    localparam int cnt_w = cnt_width(blk);
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(blk - 1);

    logic [cnt_w-1:0] wr_cnt_q, wr_cnt_d;
    logic [cnt_w-1:0] rd_cnt_q, rd_cnt_d;
    logic             in_sel_q, in_sel_d;
    logic             out_sel_q, out_sel_d;
    logic             err_q, err_d;

    bank_state_e st_a, st_b, st_in, st_out;
    logic        wr_hit, wr_done, rd_hit, rd_done;
    logic        in_err, out_err, rd_err;

    assign st_in  = (in_sel_q  == BANK_B) ? st_b : st_a;
    assign st_out = (out_sel_q == BANK_B) ? st_b : st_a;

    // Enables decode registered state only; rst merely holds them low.
    assign in_en  = ~rst & ((st_in  == EMPTY) || (st_in  == FILLING));
    assign out_en = ~rst & ((st_out == FULL)  || (st_out == DRAINING));

    assign wr_hit  = in_beat & in_en;
    assign wr_done = wr_hit & (wr_cnt_q == last_idx);
    assign rd_hit  = out_beat & out_en;
    assign rd_done = rd_hit & out_last;

    assign in_err  = in_beat  & ~in_en;
    assign out_err = out_beat & ~out_en;
    assign rd_err  = rd_hit & (out_last ? (rd_cnt_q != last_idx) : (rd_cnt_q == last_idx));

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        in_sel_d  = in_sel_q ^ wr_done;
        out_sel_d = out_sel_q ^ rd_done;
        err_d     = err_q | in_err | out_err | rd_err;

        if (wr_done)     wr_cnt_d = '0;
        else if (wr_hit) wr_cnt_d = wr_cnt_q + cnt_w'(1);

        // an overrunning read holds the count rather than wrapping into the next block
        if (rd_done)                              rd_cnt_d = '0;
        else if (rd_hit && rd_cnt_q != last_idx)  rd_cnt_d = rd_cnt_q + cnt_w'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            in_sel_q  <= BANK_A;
            out_sel_q <= BANK_A;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            in_sel_q  <= in_sel_d;
            out_sel_q <= out_sel_d;
            err_q     <= err_d;
        end
    end

    intlv_bank_fsm u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .wr_hit  (wr_hit  & (in_sel_q  == BANK_A)),
        .wr_done (wr_done & (in_sel_q  == BANK_A)),
        .rd_hit  (rd_hit  & (out_sel_q == BANK_A)),
        .rd_done (rd_done & (out_sel_q == BANK_A)),
        .state   (st_a)
    );

    intlv_bank_fsm u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .wr_hit  (wr_hit  & (in_sel_q  == BANK_B)),
        .wr_done (wr_done & (in_sel_q  == BANK_B)),
        .rd_hit  (rd_hit  & (out_sel_q == BANK_B)),
        .rd_done (rd_done & (out_sel_q == BANK_B)),
        .state   (st_b)
    );

    assign in_sel    = in_sel_q;
    assign out_sel   = out_sel_q;
    assign err       = err_q;
    assign bank_full = {st_b == FULL, st_a == FULL};

`ifdef INTLV_SCHED_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [1:0]  err_evt;
    logic [8:0]  err_sum;

    // in-side and out-side errors can land in the same cycle and count separately
    assign err_evt = {1'b0, in_err} + {1'b0, out_err} + {1'b0, rd_err};
    assign err_sum = {1'b0, err_cnt_q} + {7'd0, err_evt};

    always_comb begin
        blk_cnt_d   = blk_cnt_q + (rd_done ? 16'd1 : 16'd0);
        stall_cnt_d = stall_cnt_q;
        if (!in_en && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        err_cnt_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q   <= '0;
            stall_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign blk_cnt   = blk_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_interleave_bank_sched.sv
// tb/tb_interleave_bank_sched.sv - scoreboard bench for the ping-pong bank scheduler (row=4, col=2)
module tb_interleave_bank_sched;

    localparam int ROW = 4;
    localparam int COL = 2;
    localparam int BLK = ROW * COL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_beat = 1'b0;
    logic       out_beat = 1'b0;
    logic       out_last = 1'b0;
    logic       in_sel, out_sel, in_en, out_en, err;
    logic [1:0] bank_full;
`ifdef INTLV_SCHED_STATS_EN
    logic [15:0] blk_cnt, stall_cnt;
    logic [7:0]  err_cnt;
`endif

    interleave_bank_sched #(.row(ROW), .col(COL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_beat   (in_beat),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .in_sel    (in_sel),
        .out_sel   (out_sel),
        .in_en     (in_en),
        .out_en    (out_en),
        .bank_full (bank_full),
`ifdef INTLV_SCHED_STATS_EN
        .blk_cnt   (blk_cnt),
        .stall_cnt (stall_cnt),
        .err_cnt   (err_cnt),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int bq_a[$];
    int bq_b[$];
    int sb[$];
    int dseq = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side bank memories follow the DUT selects; the scoreboard holds arrival order.
    task automatic cyc(input logic ib, input logic ob, input logic ol);
        int got;
        int exp;
        in_beat  = ib;
        out_beat = ob;
        out_last = ol;
        #1;
        if (ib && in_en) begin
            if (in_sel) bq_b.push_back(dseq);
            else        bq_a.push_back(dseq);
            sb.push_back(dseq);
            dseq++;
        end
        if (ob && out_en && sb.size() > 0) begin
            chk("rd_bank_nonempty", (out_sel ? bq_b.size() : bq_a.size()) != 0, 1'b1);
            if ((out_sel ? bq_b.size() : bq_a.size()) != 0) begin
                got = out_sel ? bq_b.pop_front() : bq_a.pop_front();
                exp = sb.pop_front();
                chk("data", got, exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_beat  = 1'b0;
        out_beat = 1'b0;
        out_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_in_en", in_en, 1'b0);
        chk("rst_out_en", out_en, 1'b0);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_in_sel", in_sel, 1'b0);
        chk("rst_out_sel", out_sel, 1'b0);
        rst = 1'b0;
        bq_a.delete();
        bq_b.delete();
        sb.delete();
        cyc(0, 0, 0);
        chk("post_rst_in_en", in_en, 1'b1);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0);
    endtask

    task automatic drain(input int n, input int last_at);
        for (int i = 1; i <= n; i++) cyc(0, 1, i == last_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        fill(BLK);
        chk("fillA_bank_full", bank_full, 2'b01);
        chk("fillA_in_sel", in_sel, 1'b1);
        chk("fillA_out_en", out_en, 1'b1);
        chk("fillA_in_en", in_en, 1'b1);
        chk("fillA_out_sel", out_sel, 1'b0);

        fill(BLK);
        chk("fillAB_bank_full", bank_full, 2'b11);
        chk("fillAB_in_en", in_en, 1'b0);
        chk("fillAB_err", err, 1'b0);
        cyc(1, 0, 0);
        chk("overfill_err", err, 1'b1);
        chk("overfill_bank_full", bank_full, 2'b11);
        chk("overfill_sb_level", sb.size(), 2 * BLK);

        drain(BLK, BLK);
        chk("drainA_bank_full", bank_full, 2'b10);
        chk("drainA_out_sel", out_sel, 1'b1);
        chk("drainA_in_sel", in_sel, 1'b0);
        chk("drainA_in_en", in_en, 1'b1);
        chk("drainA_out_en", out_en, 1'b1);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < BLK; i++) cyc(1, 1, i == BLK - 1);
            chk("stream_in_sel", in_sel, (b % 2 == 0) ? 1'b1 : 1'b0);
            chk("stream_out_sel", out_sel, (b % 2 == 0) ? 1'b0 : 1'b1);
            chk("stream_in_en", in_en, 1'b1);
            chk("stream_out_en", out_en, 1'b1);
        end
        chk("stream_bank_full", bank_full, 2'b10);
        chk("stream_sb_level", sb.size(), BLK);

        fill(3);
        do_reset();
        fill(BLK);
        chk("fresh_bank_full", bank_full, 2'b01);
        chk("fresh_in_sel", in_sel, 1'b1);
        chk("fresh_out_en", out_en, 1'b1);
        chk("fresh_err", err, 1'b0);

        drain(5, 5);
        chk("early_last_err", err, 1'b1);
        chk("early_last_bank_full", bank_full, 2'b00);
        chk("early_last_out_sel", out_sel, 1'b1);
        chk("early_last_out_en", out_en, 1'b0);
        bq_a.delete();
        sb.delete();
        cyc(0, 1, 1);
        chk("idle_read_out_sel", out_sel, 1'b1);

        do_reset();
        fill(BLK);
        drain(BLK, 0);
        chk("overrun_err", err, 1'b1);
        chk("overrun_out_en", out_en, 1'b1);
        chk("overrun_out_sel", out_sel, 1'b0);
        cyc(0, 1, 1);
        chk("overrun_last_out_sel", out_sel, 1'b1);
        chk("overrun_last_out_en", out_en, 1'b0);

`ifdef INTLV_SCHED_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fill(BLK);
            drain(BLK, BLK);
        end
        chk("stats_blk_cnt", blk_cnt, 16'd3);
        fill(2 * BLK);
        chk("stats_stall_zero", stall_cnt, 16'd0);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0);
        chk("stats_stall_cnt", stall_cnt, 16'd10);
        cyc(1, 0, 0);
        chk("stats_err_cnt", err_cnt, 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
